multi_box_hit: RTL and testbench

- Parametrised successor to the single-box pixel test: N independent rectangles tested against the current pixel in a 2-stage pipeline.
- Per-box geometry is written through a config port into active registers and committed to shadow registers only at frame start, so objects never tear mid-frame.
- Also reports a priority-encoded hit index and per-frame sticky collisions between box 0 (ball) and every other box (paddles, walls).
- Sits between the game-logic FSM and the pixel colour mux.

---
 rtl/pong_pkg.sv | 21 ++
 rtl/multi_box_hit_if.sv | 34 +++
 rtl/box_cmp.sv | 27 ++
 rtl/multi_box_hit.sv | 138 +++++++++++++
 tb/tb_multi_box_hit.sv | 338 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/pong_pkg.sv
// Shared types and default geometry for the pong playfield boxes.
package pong_pkg;

  localparam int unsigned CoordW  = 10;
  localparam int unsigned DefNbox = 4;

  typedef struct packed {
    logic [CoordW-1:0] x;
    logic [CoordW-1:0] y;
    logic [CoordW-1:0] w;
    logic [CoordW-1:0] h;
  } box_t;

  // Default object placement on a 640x480 field
  localparam box_t BallBox     = '{x: 10'd316, y: 10'd236, w: 10'd8,   h: 10'd8};
  localparam box_t PaddleLBox  = '{x: 10'd16,  y: 10'd200, w: 10'd8,   h: 10'd64};
  localparam box_t PaddleRBox  = '{x: 10'd616, y: 10'd200, w: 10'd8,   h: 10'd64};
  localparam box_t WallTopBox  = '{x: 10'd0,   y: 10'd0,   w: 10'd640, h: 10'd8};
  localparam box_t WallBotBox  = '{x: 10'd0,   y: 10'd472, w: 10'd640, h: 10'd8};

endpackage

// File: rtl/multi_box_hit_if.sv
// Pixel, config and result signals between game logic, box tester and colour mux.
interface multi_box_hit_if #(
  parameter int unsigned NBOX = 4,
  parameter int unsigned W    = 10,
  parameter int unsigned IDXW = $clog2(NBOX)
);
  logic            frame_start;
  logic            pix_valid;
  logic [W-1:0]    X_pix;
  logic [W-1:0]    Y_pix;
  logic            cfg_we;
  logic [IDXW-1:0] cfg_idx;
  logic [W-1:0]    cfg_x;
  logic [W-1:0]    cfg_y;
  logic [W-1:0]    cfg_w;
  logic [W-1:0]    cfg_h;
  logic [NBOX-1:0] box_hit;
  logic            any_hit;
  logic [IDXW-1:0] hit_idx;
  logic            hit_valid;
  logic [NBOX-2:0] collide;

  modport master (
    output frame_start, pix_valid, X_pix, Y_pix,
    output cfg_we, cfg_idx, cfg_x, cfg_y, cfg_w, cfg_h,
    input  box_hit, any_hit, hit_idx, hit_valid, collide
  );

  modport slave (
    input  frame_start, pix_valid, X_pix, Y_pix,
    input  cfg_we, cfg_idx, cfg_x, cfg_y, cfg_w, cfg_h,
    output box_hit, any_hit, hit_idx, hit_valid, collide
  );
endinterface

// File: rtl/box_cmp.sv
// Strict-inside test of one pixel against one box; edges never count.
module box_cmp
  import pong_pkg::*;
#(
  parameter int unsigned W = CoordW
) (
  input  logic [W-1:0] x_i,
  input  logic [W-1:0] y_i,
  input  logic [W-1:0] w_i,
  input  logic [W-1:0] h_i,
  input  logic [W-1:0] px_i,
  input  logic [W-1:0] py_i,
  output logic         hit_o
);

  logic [W:0] x_end;
  logic [W:0] y_end;

  // Far edges carried at W+1 bits so boxes near the right/bottom limit do not wrap
  always_comb begin
    x_end = {1'b0, x_i} + {1'b0, w_i};
    y_end = {1'b0, y_i} + {1'b0, h_i};
    hit_o = (px_i > x_i) && ({1'b0, px_i} < x_end) &&
            (py_i > y_i) && ({1'b0, py_i} < y_end);
  end

endmodule

// File: rtl/multi_box_hit.sv
// N-box pixel hit tester: frame-synchronous shadow geometry, 2-stage pipeline,
// priority-encoded hit index and per-frame sticky ball-vs-box collisions.
module multi_box_hit
  import pong_pkg::*;
#(
  parameter int unsigned NBOX = DefNbox,
  parameter int unsigned W    = CoordW,
  parameter int unsigned IDXW = $clog2(NBOX)
) (
  input logic            pixel_clk,
  input logic            rst,
  multi_box_hit_if.slave bus
);

  typedef struct packed {
    logic [W-1:0] x;
    logic [W-1:0] y;
    logic [W-1:0] w;
    logic [W-1:0] h;
  } geom_t;

  geom_t           act_q [NBOX];
  geom_t           act_d [NBOX];
  geom_t           shd_q [NBOX];
  logic [NBOX-1:0] cmp;
  logic [NBOX-1:0] cmp_q;
  logic            vld1_q;
  logic [NBOX-1:0] hit_d;
  logic [IDXW-1:0] idx_d;
  logic [NBOX-1:0] box_hit_q;
  logic            any_hit_q;
  logic [IDXW-1:0] hit_idx_q;
  logic            hit_valid_q;
  logic            fs1_q;
  logic            fs2_q;
  logic [NBOX-2:0] pair;
  logic [NBOX-2:0] acc_q;
  logic [NBOX-2:0] collide_q;

  // Config write into the active set; indices with no box match nothing and are dropped
  always_comb begin
    for (int i = 0; i < int'(NBOX); i++) begin
      act_d[i] = act_q[i];
      if (bus.cfg_we && (bus.cfg_idx == IDXW'(i))) begin
        act_d[i] = '{x: bus.cfg_x, y: bus.cfg_y, w: bus.cfg_w, h: bus.cfg_h};
      end
    end
  end

  // Active geometry follows writes; shadows snapshot it (incl. same-cycle write) at frame start
  always_ff @(posedge pixel_clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < int'(NBOX); i++) begin
        act_q[i] <= '0;
        shd_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < int'(NBOX); i++) begin
        act_q[i] <= act_d[i];
        if (bus.frame_start) shd_q[i] <= act_d[i];
      end
    end
  end

  for (genvar g = 0; g < NBOX; g++) begin : g_cmp
    box_cmp #(
      .W (W)
    ) u_box_cmp (
      .x_i   (shd_q[g].x),
      .y_i   (shd_q[g].y),
      .w_i   (shd_q[g].w),
      .h_i   (shd_q[g].h),
      .px_i  (bus.X_pix),
      .py_i  (bus.Y_pix),
      .hit_o (cmp[g])
    );
  end

  // Mask by stage-1 valid and pick the lowest-numbered hit
  always_comb begin
    hit_d = vld1_q ? cmp_q : '0;
    idx_d = '0;
    for (int i = int'(NBOX) - 1; i >= 0; i--) begin
      if (hit_d[i]) idx_d = IDXW'(i);
    end
  end

  // Box 0 overlapping box i at the current stage-2 pixel
  always_comb begin
    pair = '0;
    for (int i = 1; i < int'(NBOX); i++) begin
      pair[i-1] = box_hit_q[0] & box_hit_q[i];
    end
  end

  // Two pipeline stages plus the matching frame_start delay line
  always_ff @(posedge pixel_clk or posedge rst) begin
    if (rst) begin
      cmp_q       <= '0;
      vld1_q      <= 1'b0;
      box_hit_q   <= '0;
      any_hit_q   <= 1'b0;
      hit_idx_q   <= '0;
      hit_valid_q <= 1'b0;
      fs1_q       <= 1'b0;
      fs2_q       <= 1'b0;
    end else begin
      cmp_q       <= cmp;
      vld1_q      <= bus.pix_valid;
      box_hit_q   <= hit_d;
      any_hit_q   <= |hit_d;
      hit_idx_q   <= idx_d;
      hit_valid_q <= vld1_q;
      fs1_q       <= bus.frame_start;
      fs2_q       <= fs1_q;
    end
  end

  // Sticky collision flags: published and cleared on the pipeline-aligned frame pulse
  always_ff @(posedge pixel_clk or posedge rst) begin
    if (rst) begin
      acc_q     <= '0;
      collide_q <= '0;
    end else if (fs2_q) begin
      collide_q <= acc_q | pair;
      acc_q     <= '0;
    end else begin
      acc_q     <= acc_q | pair;
    end
  end

  assign bus.box_hit   = box_hit_q;
  assign bus.any_hit   = any_hit_q;
  assign bus.hit_idx   = hit_idx_q;
  assign bus.hit_valid = hit_valid_q;
  assign bus.collide   = collide_q;

endmodule

// File: tb/tb_multi_box_hit.sv
// Self-checking bench for multi_box_hit: directed scenarios plus randomized traffic
// checked against a frame-level behavioural model.
module tb_multi_box_hit;

  localparam int NB = 4;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  multi_box_hit_if #(.NBOX(4), .W(10)) bus ();
  multi_box_hit_if #(.NBOX(5), .W(10)) bus5 ();

  multi_box_hit #(.NBOX(4), .W(10)) u_dut (
    .pixel_clk (clk),
    .rst       (rst),
    .bus       (bus)
  );

  multi_box_hit #(.NBOX(5), .W(10)) u_dut5 (
    .pixel_clk (clk),
    .rst       (rst),
    .bus       (bus5)
  );

  int unsigned pass_cnt = 0;
  int unsigned chk_cnt  = 0;

  // Model: geometry as plain integers, results delayed two clocks, frame sticky OR
  int ax[NB], ay[NB], aw[NB], ah[NB];
  int sx[NB], sy[NB], sw[NB], sh[NB];
  logic [3:0] s1_hit, m_hit;
  logic       s1_v, m_v, fs1, fs2;
  logic [2:0] acc, m_col;

  function automatic bit inside_box(int x, int y, int w, int h, int px, int py);
    return (px > x) && (px < x + w) && (py > y) && (py < y + h);
  endfunction

  function automatic logic [1:0] lowest(logic [3:0] v);
    for (int i = 0; i < 4; i++) if (v[i]) return 2'(i);
    return 2'd0;
  endfunction

  function automatic logic [10:0] model_vec();
    return {m_hit, |m_hit, lowest(m_hit), m_v, m_col};
  endfunction

  function automatic logic [10:0] dut_vec();
    return {bus.box_hit, bus.any_hit, bus.hit_idx, bus.hit_valid, bus.collide};
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NB; i++) begin
      ax[i] = 0; ay[i] = 0; aw[i] = 0; ah[i] = 0;
      sx[i] = 0; sy[i] = 0; sw[i] = 0; sh[i] = 0;
    end
    s1_hit = '0; m_hit = '0; s1_v = 0; m_v = 0; fs1 = 0; fs2 = 0;
    acc = '0; m_col = '0;
  endtask

  task automatic idle_inputs();
    bus.frame_start = 0; bus.pix_valid = 0; bus.X_pix = '0; bus.Y_pix = '0;
    bus.cfg_we = 0; bus.cfg_idx = '0; bus.cfg_x = '0; bus.cfg_y = '0;
    bus.cfg_w = '0; bus.cfg_h = '0;
    bus5.frame_start = 0; bus5.pix_valid = 0; bus5.X_pix = '0; bus5.Y_pix = '0;
    bus5.cfg_we = 0; bus5.cfg_idx = '0; bus5.cfg_x = '0; bus5.cfg_y = '0;
    bus5.cfg_w = '0; bus5.cfg_h = '0;
  endtask

  // Advance the model with the inputs now on the bus, then clock once
  task automatic cycle();
    logic [3:0] e;
    logic [2:0] p;
    e = '0;
    for (int i = 0; i < NB; i++)
      if (bus.pix_valid && inside_box(sx[i], sy[i], sw[i], sh[i], int'(bus.X_pix),
                                      int'(bus.Y_pix))) e[i] = 1'b1;
    for (int i = 1; i < NB; i++) p[i-1] = m_hit[0] & m_hit[i];
    if (fs2) begin
      m_col = acc | p;
      acc   = '0;
    end else begin
      acc = acc | p;
    end
    m_hit = s1_hit; m_v = s1_v;
    s1_hit = e;     s1_v = bus.pix_valid;
    fs2 = fs1;      fs1 = bus.frame_start;
    if (bus.cfg_we) begin
      ax[bus.cfg_idx] = int'(bus.cfg_x); ay[bus.cfg_idx] = int'(bus.cfg_y);
      aw[bus.cfg_idx] = int'(bus.cfg_w); ah[bus.cfg_idx] = int'(bus.cfg_h);
    end
    if (bus.frame_start)
      for (int i = 0; i < NB; i++) begin
        sx[i] = ax[i]; sy[i] = ay[i]; sw[i] = aw[i]; sh[i] = ah[i];
      end
    @(posedge clk);
    #1;
    bus.frame_start = 0; bus.cfg_we = 0;
    bus5.frame_start = 0; bus5.cfg_we = 0;
  endtask

  task automatic pix(int x, int y, bit v);
    bus.X_pix = 10'(x); bus.Y_pix = 10'(y); bus.pix_valid = v;
    cycle();
  endtask

  task automatic wr(int idx, int x, int y, int w, int h, bit fs);
    bus.cfg_we = 1; bus.cfg_idx = 2'(idx);
    bus.cfg_x = 10'(x); bus.cfg_y = 10'(y); bus.cfg_w = 10'(w); bus.cfg_h = 10'(h);
    bus.frame_start = fs; bus.pix_valid = 0;
    cycle();
  endtask

  task automatic frame_pulse();
    bus.frame_start = 1; bus.pix_valid = 0;
    cycle();
  endtask

  task automatic scan(int lo, int hi);
    for (int y = lo; y <= hi; y++)
      for (int x = lo; x <= hi; x++) pix(x, y, 1);
  endtask

  task automatic test_reset();
    idle_inputs();
    model_reset();
    #1 rst = 1;
    #1;
    chk_cnt++;
    if (dut_vec() !== 11'd0) $display("FAIL reset_outputs got=%b want=0", dut_vec());
    else pass_cnt++;
    @(posedge clk); @(posedge clk); #1;
    rst = 0;
    pix(0, 0, 0);
    pix(0, 0, 0);
    chk_cnt++;
    if (dut_vec() !== model_vec()) $display("FAIL reset_idle got=%b want=%b", dut_vec(),
                                            model_vec());
    else pass_cnt++;
  endtask

  task automatic test_idx_ignored();
    bus5.cfg_x = '0; bus5.cfg_y = '0; bus5.cfg_w = 10'd1023; bus5.cfg_h = 10'd1023;
    bus5.cfg_we = 1; bus5.cfg_idx = 3'd5; cycle();
    bus5.cfg_we = 1; bus5.cfg_idx = 3'd7; cycle();
    bus5.frame_start = 1; cycle();
    bus5.X_pix = 10'd100; bus5.Y_pix = 10'd100; bus5.pix_valid = 1;
    cycle(); cycle(); cycle();
    chk_cnt++;
    if (bus5.box_hit !== 5'b0 || bus5.any_hit !== 1'b0)
      $display("FAIL idx_out_of_range got=%b want=00000", bus5.box_hit);
    else pass_cnt++;
    bus5.cfg_we = 1; bus5.cfg_idx = 3'd4; bus5.frame_start = 1; cycle();
    cycle(); cycle(); cycle();
    chk_cnt++;
    if (bus5.box_hit !== 5'b10000 || bus5.hit_idx !== 3'd4)
      $display("FAIL idx_in_range got=%b/%0d want=10000/4", bus5.box_hit, bus5.hit_idx);
    else pass_cnt++;
    bus5.pix_valid = 0;
  endtask

  task automatic test_basic_latency();
    wr(0, 100, 100, 10, 10, 1'b1);
    pix(105, 105, 1);
    chk_cnt++;
    if (bus.box_hit !== 4'b0000) $display("FAIL latency_early got=%b want=0000", bus.box_hit);
    else pass_cnt++;
    pix(100, 105, 1);
    chk_cnt++;
    if ({bus.box_hit, bus.any_hit, bus.hit_idx, bus.hit_valid} !== {4'b0001, 1'b1, 2'd0, 1'b1})
      $display("FAIL basic_hit got=%b/%b/%0d/%b want=0001/1/0/1", bus.box_hit, bus.any_hit,
               bus.hit_idx, bus.hit_valid);
    else pass_cnt++;
    pix(110, 105, 1);
    chk_cnt++;
    if (bus.box_hit !== 4'b0000) $display("FAIL left_edge got=%b want=0000", bus.box_hit);
    else pass_cnt++;
    pix(0, 0, 0);
    chk_cnt++;
    if (bus.box_hit !== 4'b0000) $display("FAIL right_edge got=%b want=0000", bus.box_hit);
    else pass_cnt++;
  endtask

  task automatic test_shadow();
    wr(1, 200, 100, 10, 10, 1'b0);
    pix(205, 105, 1); pix(205, 105, 1); pix(205, 105, 1);
    chk_cnt++;
    if (bus.box_hit !== 4'b0000) $display("FAIL shadow_premature got=%b want=0000", bus.box_hit);
    else pass_cnt++;
    frame_pulse();
    pix(205, 105, 1); pix(205, 105, 1); pix(205, 105, 1);
    chk_cnt++;
    if (bus.box_hit !== 4'b0010) $display("FAIL shadow_commit got=%b want=0010", bus.box_hit);
    else pass_cnt++;
  endtask

  task automatic test_priority();
    wr(1, 290, 290, 20, 20, 1'b0);
    wr(2, 295, 295, 20, 20, 1'b1);  // write coinciding with frame_start
    pix(300, 300, 1); pix(300, 300, 1); pix(300, 300, 1);
    chk_cnt++;
    if ({bus.box_hit, bus.any_hit, bus.hit_idx} !== {4'b0110, 1'b1, 2'd1})
      $display("FAIL priority got=%b/%b/%0d want=0110/1/1", bus.box_hit, bus.any_hit,
               bus.hit_idx);
    else pass_cnt++;
    pix(300, 300, 0); pix(300, 300, 0); pix(300, 300, 0);
    chk_cnt++;
    if ({bus.box_hit, bus.any_hit, bus.hit_idx, bus.hit_valid} !== 8'd0)
      $display("FAIL invalid_pixel got=%b/%b/%0d/%b want=0000/0/0/0", bus.box_hit,
               bus.any_hit, bus.hit_idx, bus.hit_valid);
    else pass_cnt++;
  endtask

  task automatic test_edges();
    wr(2, 1020, 500, 10, 10, 1'b0);
    wr(1, 400, 400, 1, 10, 1'b1);
    pix(1023, 505, 1); pix(1023, 505, 1); pix(1023, 505, 1);
    chk_cnt++;
    if (bus.box_hit !== 4'b0100) $display("FAIL no_wrap got=%b want=0100", bus.box_hit);
    else pass_cnt++;
    pix(1020, 505, 1); pix(1020, 505, 1); pix(1020, 505, 1);
    chk_cnt++;
    if (bus.box_hit !== 4'b0000) $display("FAIL wrap_left_edge got=%b want=0000", bus.box_hit);
    else pass_cnt++;
    pix(401, 405, 1); pix(400, 405, 1); pix(401, 405, 1);
    chk_cnt++;
    if (bus.box_hit !== 4'b0000) $display("FAIL width_one got=%b want=0000", bus.box_hit);
    else pass_cnt++;
  endtask

  task automatic test_collision();
    wr(0, 50, 50, 8, 8, 1'b0);
    wr(1, 0, 0, 0, 0, 1'b0);
    wr(2, 0, 0, 0, 0, 1'b0);
    wr(3, 55, 55, 8, 8, 1'b1);
    scan(45, 66);
    frame_pulse();
    pix(0, 0, 0); pix(0, 0, 0); pix(0, 0, 0);
    chk_cnt++;
    if (bus.collide !== 3'b100 || dut_vec() !== model_vec())
      $display("FAIL collide_set got=%b want=100", bus.collide);
    else pass_cnt++;
    scan(45, 66);
    chk_cnt++;
    if (bus.collide !== 3'b100) $display("FAIL collide_hold got=%b want=100", bus.collide);
    else pass_cnt++;
    wr(3, 200, 200, 8, 8, 1'b0);
    frame_pulse();
    pix(0, 0, 0); pix(0, 0, 0); pix(0, 0, 0);
    chk_cnt++;
    if (bus.collide !== 3'b100) $display("FAIL collide_prev_frame got=%b want=100", bus.collide);
    else pass_cnt++;
    scan(45, 66);
    frame_pulse();
    pix(0, 0, 0); pix(0, 0, 0); pix(0, 0, 0);
    chk_cnt++;
    if (bus.collide !== 3'b000 || dut_vec() !== model_vec())
      $display("FAIL collide_clear got=%b want=000", bus.collide);
    else pass_cnt++;
  endtask

  task automatic test_reset_mid();
    wr(3, 55, 55, 8, 8, 1'b1);
    scan(45, 66);
    frame_pulse();
    pix(0, 0, 0); pix(0, 0, 0); pix(0, 0, 0);
    chk_cnt++;
    if (bus.collide !== 3'b100) $display("FAIL pre_reset_collide got=%b want=100", bus.collide);
    else pass_cnt++;
    pix(56, 56, 1); pix(56, 56, 1);
    #2 rst = 1;
    #1;
    chk_cnt++;
    if (dut_vec() !== 11'd0) $display("FAIL async_reset got=%b want=0", dut_vec());
    else pass_cnt++;
    model_reset();
    @(posedge clk); #1;
    rst = 0;
    pix(56, 56, 1); pix(56, 56, 1); pix(56, 56, 1);
    chk_cnt++;
    if (bus.box_hit !== 4'b0000) $display("FAIL post_reset_hit got=%b want=0000", bus.box_hit);
    else pass_cnt++;
    frame_pulse();
    pix(56, 56, 1); pix(56, 56, 1); pix(56, 56, 1);
    chk_cnt++;
    if (bus.box_hit !== 4'b0000) $display("FAIL post_reset_commit got=%b want=0000",
                                          bus.box_hit);
    else pass_cnt++;
    wr(0, 50, 50, 8, 8, 1'b1);
    pix(54, 54, 1); pix(54, 54, 1); pix(54, 54, 1);
    chk_cnt++;
    if (bus.box_hit !== 4'b0001) $display("FAIL post_reset_recover got=%b want=0001",
                                          bus.box_hit);
    else pass_cnt++;
  endtask

  task automatic test_random();
    int x, y, w, h, px, py;
    for (int n = 0; n < 1500; n++) begin
      if ($urandom_range(0, 7) == 0) begin
        x = ($urandom_range(0, 7) == 0) ? int'($urandom_range(1000, 1023))
                                        : int'($urandom_range(0, 60));
        y = int'($urandom_range(0, 60));
        w = int'($urandom_range(0, 25));
        h = int'($urandom_range(0, 25));
        bus.cfg_we = 1; bus.cfg_idx = 2'($urandom_range(0, 3));
        bus.cfg_x = 10'(x); bus.cfg_y = 10'(y); bus.cfg_w = 10'(w); bus.cfg_h = 10'(h);
      end
      bus.frame_start = ($urandom_range(0, 39) == 0);
      px = ($urandom_range(0, 3) == 0) ? int'($urandom_range(990, 1023))
                                       : int'($urandom_range(0, 90));
      py = int'($urandom_range(0, 90));
      bus.X_pix = 10'(px); bus.Y_pix = 10'(py);
      bus.pix_valid = ($urandom_range(0, 3) != 0);
      cycle();
      chk_cnt++;
      if (dut_vec() !== model_vec())
        $display("FAIL random_cycle%0d got=%b want=%b", n, dut_vec(), model_vec());
      else pass_cnt++;
    end
  endtask

  initial begin
    test_reset();
    test_idx_ignored();
    test_basic_latency();
    test_shadow();
    test_priority();
    test_edges();
    test_collision();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
